regfile_rename: RTL

//   Parametrised architectural register file with per-register rename status (busy bit + ROB tag)
//   for the out-of-order core. Dispatch marks a destination busy with its ROB tag; commit writes
//   the value and clears busy only if the tag still matches. NRD combinational read ports return

---
 rtl/regfile_rename_pkg.sv | 12 +
 rtl/regfile_rename_rdport.sv | 42 ++++
 rtl/regfile_rename.sv | 85 ++++++++
 3 files changed

// File: rtl/regfile_rename_pkg.sv
// Shared widths and constants for the renamed architectural register file.
package regfile_rename_pkg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned AW     = 5;
  localparam int unsigned TAGW   = 4;
  localparam int unsigned NRD    = 2;
  localparam int unsigned RegNum = NREG;

  localparam logic [XLEN-1:0] ZeroWord  = '0;
  localparam logic            RstEnable = 1'b0;
endpackage

// File: rtl/regfile_rename_rdport.sv
// One combinational read port: zero rules, commit bypass, then stored state.
module regfile_rename_rdport
  import regfile_rename_pkg::*;
(
  input  logic            rst_i,
  input  logic            ready_i,
  input  logic            en_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [XLEN-1:0] regs_i [RegNum],
  input  logic [TAGW-1:0] tags_i [RegNum],
  input  logic [RegNum-1:0] busy_i,
  input  logic            cmt_en_i,
  input  logic [AW-1:0]   cmt_rd_i,
  input  logic [TAGW-1:0] cmt_tag_i,
  input  logic [XLEN-1:0] cmt_data_i,
  output logic [XLEN-1:0] data_o,
  output logic            busy_o,
  output logic [TAGW-1:0] tag_o
);

  logic hit_c;

  // Bypass only when this commit actually retires the pending producer.
  assign hit_c = cmt_en_i && ready_i && (addr_i == cmt_rd_i) &&
                 busy_i[addr_i] && (tags_i[addr_i] == cmt_tag_i);

  always_comb begin
    data_o = ZeroWord;
    busy_o = 1'b0;
    tag_o  = '0;
    if ((rst_i != RstEnable) && en_i && (addr_i != '0)) begin
      if (hit_c) begin
        data_o = cmt_data_i;
      end else begin
        data_o = regs_i[addr_i];
        busy_o = busy_i[addr_i];
        tag_o  = tags_i[addr_i];
      end
    end
  end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register busy bit and producer ROB tag.
module regfile_rename
  import regfile_rename_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ready_i,
  input  logic                 flush_i,
  input  logic                 iss_en_i,
  input  logic [AW-1:0]        iss_rd_i,
  input  logic [TAGW-1:0]      iss_tag_i,
  input  logic                 cmt_en_i,
  input  logic [AW-1:0]        cmt_rd_i,
  input  logic [TAGW-1:0]      cmt_tag_i,
  input  logic [XLEN-1:0]      cmt_data_i,
  input  logic [NRD-1:0]       rd_en_i,
  input  logic [NRD*AW-1:0]    rd_addr_i,
  output logic [NRD*XLEN-1:0]  rd_data_o,
  output logic [NRD-1:0]       rd_busy_o,
  output logic [NRD*TAGW-1:0]  rd_tag_o
);

  logic [XLEN-1:0]   regs_q [RegNum];
  logic [XLEN-1:0]   regs_d [RegNum];
  logic [TAGW-1:0]   tag_q  [RegNum];
  logic [TAGW-1:0]   tag_d  [RegNum];
  logic [RegNum-1:0] busy_q;
  logic [RegNum-1:0] busy_d;

  // Commit first, then dispatch (younger rename wins busy/tag), flush last.
  always_comb begin
    regs_d = regs_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (ready_i) begin
      if (cmt_en_i && (cmt_rd_i != '0)) begin
        regs_d[cmt_rd_i] = cmt_data_i;
        if (tag_q[cmt_rd_i] == cmt_tag_i) begin
          busy_d[cmt_rd_i] = 1'b0;
        end
      end
      if (iss_en_i && (iss_rd_i != '0)) begin
        busy_d[iss_rd_i] = 1'b1;
        tag_d[iss_rd_i]  = iss_tag_i;
      end
      if (flush_i) begin
        busy_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (rst_i == RstEnable) begin
      for (int i = 0; i < int'(RegNum); i++) begin
        regs_q[i] <= ZeroWord;
        tag_q[i]  <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
    end
  end

  for (genvar g = 0; g < int'(NRD); g++) begin : g_rd
    regfile_rename_rdport u_rdport (
      .rst_i      (rst_i),
      .ready_i    (ready_i),
      .en_i       (rd_en_i[g]),
      .addr_i     (rd_addr_i[g*AW +: AW]),
      .regs_i     (regs_q),
      .tags_i     (tag_q),
      .busy_i     (busy_q),
      .cmt_en_i   (cmt_en_i),
      .cmt_rd_i   (cmt_rd_i),
      .cmt_tag_i  (cmt_tag_i),
      .cmt_data_i (cmt_data_i),
      .data_o     (rd_data_o[g*XLEN +: XLEN]),
      .busy_o     (rd_busy_o[g]),
      .tag_o      (rd_tag_o[g*TAGW +: TAGW])
    );
  end

endmodule
